// File: rtl/l2_ctrl.sv
// L2 sequencing controller: lookup, 4-word line fill on read miss, write-through.
// Define L2_CTRL_CWF_EN for critical-word-first fill ordering.
module l2_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_busy,
  output logic                  l2_valid,
  output logic                  l2_we,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [DATA_WIDTH-1:0] l2_wdata,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  input  logic                  l2_hit,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_mark_valid,
  output logic                  mm_req,
  output logic                  mm_we,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [DATA_WIDTH-1:0] mm_wdata,
  input  logic                  mm_ready,
  input  logic [DATA_WIDTH-1:0] mm_rdata
);

  localparam int BOFF = $clog2(DATA_WIDTH / 8);
  localparam int LOFF = $clog2(LINE_SIZE);
  localparam int CW   = LOFF - BOFF;
  localparam logic [CW-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL, WRITE, RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         widx, idx;
  logic [ADDR_WIDTH-1:0] fill_a;

  assign widx = addr_q[LOFF-1:BOFF];

`ifdef L2_CTRL_CWF_EN
  // Wrapping order: the requested word is always the first transfer.
  assign idx = widx + cnt_q;
`else
  assign idx = cnt_q;
`endif

  assign fill_a = {addr_q[ADDR_WIDTH-1:LOFF], idx, {BOFF{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          state_d = WRITE;
        end else if (l2_hit) begin
          rdata_d = l2_rdata;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (mm_ready) begin
          if (idx == widx) rdata_d = mm_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = RESP;
        end
      end
      WRITE: begin
        if (mm_ready) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdata       = rdata_q;
    cpu_ready       = 1'b0;
    cpu_busy        = (state_q != IDLE);
    l2_valid        = 1'b0;
    l2_we           = 1'b0;
    l2_addr         = '0;
    l2_wdata        = '0;
    fill_en         = 1'b0;
    fill_addr       = '0;
    fill_data       = '0;
    fill_mark_valid = 1'b0;
    mm_req          = 1'b0;
    mm_we           = 1'b0;
    mm_addr         = '0;
    mm_wdata        = '0;
    case (state_q)
      LOOKUP: begin
        l2_valid = 1'b1;
        l2_we    = we_q;
        l2_addr  = addr_q;
        l2_wdata = wdata_q;
      end
      FILL: begin
        mm_req  = 1'b1;
        mm_addr = fill_a;
        if (mm_ready) begin
          fill_en         = 1'b1;
          fill_addr       = fill_a;
          fill_data       = mm_rdata;
          fill_mark_valid = (cnt_q == LAST);
        end
      end
      WRITE: begin
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_addr  = addr_q;
        mm_wdata = wdata_q;
      end
      RESP:    cpu_ready = 1'b1;
      default: ;
    endcase
  end

endmodule
